// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for mem_bridge: command/state encodings and watchdog sizing.
package mem_bridge_pkg;

  localparam int unsigned AW_DEF      = 9;
  localparam int unsigned DW_DEF      = 16;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned WDOG_W      = 8;

  localparam logic [15:0] DEAD_WORD = 16'hDEAD;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_ILL   = 2'b11
  } mem_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/mem_bridge_wdog.sv
// Access watchdog: clearable up-counter; tc_o is high in the cycle the count equals TIMEOUT-1,
// i.e. in the TIMEOUT-th enabled cycle after a clear.
module mem_bridge_wdog
  import mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              tc_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  // Flag is registered against the next count so it lines up with the cycle it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == LAST);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/mem_bridge.sv
// CPU mem_cmd to req/ready memory bridge with controller stall, read-data hold and watchdog.
// Optional MMIO LED/switch registers when MEM_BRIDGE_MMIO_EN is defined.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned    AW          = AW_DEF,
  parameter int unsigned    DW          = DW_DEF,
  parameter int unsigned    TIMEOUT     = TIMEOUT_DEF,
  parameter logic [AW-1:0]  IO_LED_ADDR = AW'('h100),
  parameter logic [AW-1:0]  IO_SW_ADDR  = AW'('h140)
) (
  input  logic          clk,
  input  logic          reset_n,
`ifdef MEM_BRIDGE_MMIO_EN
  output logic [7:0]    io_led,
  input  logic [7:0]    io_sw,
`endif
  input  logic [1:0]    cmd_mem_cmd,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          cmd_stall,
  output logic          cmd_rvalid,
  output logic [DW-1:0] cmd_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ready,
  input  logic [DW-1:0] m_rdata,
  output logic          err
);

`ifdef MEM_BRIDGE_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  state_t        state_q;
  logic          m_req_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;
  logic          err_q;

  mem_cmd_t cmd_c;
  logic     acc_c;
  logic     mmio_led_c;
  logic     mmio_sw_c;
  logic     mmio_c;
  logic     wdog_tc;

  assign cmd_c      = mem_cmd_t'(cmd_mem_cmd);
  assign acc_c      = (cmd_c == CMD_READ) || (cmd_c == CMD_WRITE);
  assign mmio_led_c = MMIO_EN && (cmd_c == CMD_WRITE) && (cmd_addr == IO_LED_ADDR);
  assign mmio_sw_c  = MMIO_EN && (cmd_c == CMD_READ) && (cmd_addr == IO_SW_ADDR);
  assign mmio_c     = mmio_led_c || mmio_sw_c;

  // Stall must rise in the same cycle the command is seen so the controller holds it.
  assign cmd_stall = (state_q == ST_REQ) || ((state_q == ST_IDLE) && acc_c);

  mem_bridge_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   ((state_q == ST_IDLE) && acc_c && !mmio_c),
    .en_i    (state_q == ST_REQ),
    .tc_o    (wdog_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_c == CMD_ILL) begin
            err_q <= 1'b1;
          end else if (acc_c) begin
            m_we_q    <= (cmd_c == CMD_WRITE);
            m_addr_q  <= cmd_addr;
            m_wdata_q <= cmd_wdata;
            if (mmio_c) begin
              rvalid_q <= mmio_sw_c;
`ifdef MEM_BRIDGE_MMIO_EN
              if (mmio_sw_c) rdata_q <= DW'(io_sw);
`endif
              state_q  <= ST_RESP;
            end else begin
              m_req_q <= 1'b1;
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // A ready in the terminal watchdog cycle still completes normally.
          if (m_ready) begin
            m_req_q <= 1'b0;
            if (!m_we_q) begin
              rdata_q  <= m_rdata;
              rvalid_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end else if (wdog_tc) begin
            m_req_q <= 1'b0;
            err_q   <= 1'b1;
            if (!m_we_q) begin
              rdata_q  <= DW'(DEAD_WORD);
              rvalid_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_BRIDGE_MMIO_EN
  logic [7:0] io_led_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_led_q <= '0;
    end else if ((state_q == ST_IDLE) && mmio_led_c) begin
      io_led_q <= cmd_wdata[7:0];
    end
  end

  assign io_led = io_led_q;
`endif

  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
  assign cmd_rdata  = rdata_q;
  assign cmd_rvalid = rvalid_q;
  assign err        = err_q;

endmodule
